// File: rtl/zion_bitmap_oh_scanner.sv
// Bitmap-to-onehot scanner: accepts one bitmap and emits one handshaked beat
// per set bit (LSB-first or MSB-first), with index, last flag and remaining count.
module zion_bitmap_oh_scanner #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    parameter int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iClr,
    input  logic             iVld,
    output logic             iRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             oRdy,
    output logic [WIDTH-1:0] oOh,
    output logic [IDX_W-1:0] oIdx,
    output logic             oLast,
    output logic [CNT_W-1:0] oCnt
);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("zion_bitmap_oh_scanner: WIDTH must be >= 2");
`ifdef CHECK_ERR_EXIT
            $fatal(1, "zion_bitmap_oh_scanner: WIDTH must be >= 2");
`endif
        end
    endgenerate

    // Residual bits of the bitmap in flight; rem == 0 is the idle state.
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] pop_cnt;
    logic             found;
    logic             busy;
    logic             load;
    logic             consume;

    // Priority pick over rem in the configured direction.
    always_comb begin
        pick_oh = '0;
        found   = 1'b0;
        if (MSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (rem[i] && !found) begin
                    pick_oh[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (rem[i] && !found) begin
                    pick_oh[i] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (pick_oh[i]) begin
                pick_idx = pick_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + CNT_W'(rem[i]);
        end
    end

    assign busy  = |rem;
    assign oVld  = busy;
    assign oOh   = pick_oh;
    assign oIdx  = pick_idx;
    assign oCnt  = pop_cnt;
    assign oLast = busy & ((rem & ~pick_oh) == '0);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. iRdy may rise during the final beat so the next bitmap
    // is taken on the same edge the last beat leaves; iClr blocks acceptance.
    assign iRdy    = ~iClr & (~busy | (oRdy & oLast));
    assign load    = iVld & iRdy;
    assign consume = busy & oRdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem <= '0;
        end else if (iClr) begin
            rem <= '0;
        end else if (load) begin
            rem <= iDat;
        end else if (consume) begin
            rem <= rem & ~pick_oh;
        end
    end

endmodule
